// File: rtl/LDPC_pkg.sv
// Shared constants and types for the LDPC codeword block reader.
// Bank geometry, base-graph limits and reader FSM states.
package LDPC_pkg;
  localparam int MAX_ZC       = 384;
  localparam int MAX_BLOCKS   = 68;
  localparam int IDX_W        = 7;
  localparam int ZC_W         = 9;
  localparam int KB_BG1       = 22;
  localparam int KB_BG2       = 10;
  localparam int MAX_NPAR_BG1 = 46;
  localparam int MAX_NPAR_BG2 = 42;
  localparam int MIN_NPAR     = 4;
  localparam int MIN_ZC       = 2;
  localparam int PUNCT_BLOCKS = 2;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;
endpackage

// File: rtl/zc_mask_gen.sv
// Thermometer mask: bit b set when b < zc.
// Shared with the encoder datapath.
module zc_mask_gen
  import LDPC_pkg::*;
(
  input  logic [ZC_W-1:0]   zc_i,
  output logic [MAX_ZC-1:0] mask_o
);

  for (genvar b = 0; b < MAX_ZC; b++) begin : g_bit
    assign mask_o[b] = (ZC_W'(b) < zc_i);
  end

endmodule

// File: rtl/codeword_block_reader.sv
// Captures one assembled codeword bank and streams it
// one Zc-wide block per beat with puncturing and zc masking.
module codeword_block_reader
  import LDPC_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [MAX_ZC-1:0] load_blocks [MAX_BLOCKS],
  input  logic              bg_sel,
  input  logic [ZC_W-1:0]   zc,
  input  logic [IDX_W-1:0]  n_parity,
  input  logic              punct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAX_ZC-1:0] out_block,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last,
  output logic              err_cfg
);

  rd_state_t         state_q;
  logic              valid_q;
  logic              first_q;
  logic              last_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  end_q;
  logic [ZC_W-1:0]   zc_q;
  logic [MAX_ZC-1:0] bank_q [MAX_BLOCKS];

  logic [IDX_W-1:0]  kb;
  logic [IDX_W-1:0]  npar_max;
  logic [IDX_W-1:0]  start_d;
  logic [IDX_W-1:0]  end_d;
  logic [IDX_W-1:0]  idx_inc;
  logic              cfg_ok;
  logic              accept;
  logic [MAX_ZC-1:0] mask;

  always_comb begin
    kb       = bg_sel ? IDX_W'(KB_BG2) : IDX_W'(KB_BG1);
    npar_max = bg_sel ? IDX_W'(MAX_NPAR_BG2)
                      : IDX_W'(MAX_NPAR_BG1);
    cfg_ok   = (zc >= ZC_W'(MIN_ZC))
             && (zc <= ZC_W'(MAX_ZC))
             && (n_parity >= IDX_W'(MIN_NPAR))
             && (n_parity <= npar_max);
    start_d  = punct_en ? IDX_W'(PUNCT_BLOCKS) : '0;
    end_d    = kb + n_parity - IDX_W'(1);
    idx_inc  = idx_q + IDX_W'(1);
    accept   = (state_q == IDLE) && load_valid && cfg_ok;
  end

  // First STREAM cycle only primes out_valid, giving one idle beat after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      end_q   <= '0;
      zc_q    <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            if (cfg_ok) begin
              state_q <= STREAM;
              idx_q   <= start_d;
              end_q   <= end_d;
              zc_q    <= zc;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (idx_q == end_q);
          end else if (out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_inc;
              first_q <= 1'b0;
              last_q  <= (idx_inc == end_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      bank_q <= load_blocks;
    end
  end

  zc_mask_gen u_mask (
    .zc_i   (zc_q),
    .mask_o (mask)
  );

  assign load_ready = (state_q == IDLE);
  assign out_valid  = valid_q;
  assign out_first  = first_q;
  assign out_last   = last_q;
  assign out_idx    = idx_q;
  assign err_cfg    = err_q;
  assign out_block  = valid_q ? (bank_q[idx_q] & mask) : '0;

endmodule
